// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and elaboration helpers for fifo_param
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_DEPTH = 32;

    // Almost-flag thresholds are clamped into the legal occupancy range 0..depth.
    function automatic int clamp_level(input int level, input int depth);
        if (level < 0) begin
            return 0;
        end
        if (level > depth) begin
            return depth;
        end
        return level;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector with registered previous value
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic out_o
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= in_i;
        end
    end

    assign out_o = in_i & ~prev_q;

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with edge/level events and sticky errors
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2,
    parameter int EDGE_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  inp_data,
    input  logic              clear_err,
    output logic [WIDTH-1:0]  out_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   cur_size,
    output logic              overflow,
    output logic              underflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] AF_T = CNT_W'(clamp_level(AF_LEVEL, DEPTH));
    localparam logic [ADDR_W:0] AE_T = CNT_W'(clamp_level(AE_LEVEL, DEPTH));
    localparam logic [ADDR_W:0] ONE  = CNT_W'(1);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("fifo_param: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ev, pop_ev;
    logic              push_acc, pop_acc;

    if (EDGE_MODE != 0) begin : g_edge
        edge_pulse u_push_edge (.clk(clk), .reset(reset), .in_i(push), .out_o(push_ev));
        edge_pulse u_pop_edge  (.clk(clk), .reset(reset), .in_i(pop),  .out_o(pop_ev));
    end else begin : g_level
        assign push_ev = push;
        assign pop_ev  = pop;
    end

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                          (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign cur_size     = wr_ptr_q - rd_ptr_q;
    assign almost_empty = (cur_size <= AE_T);
    assign almost_full  = (cur_size >= AF_T);

    assign push_acc = push_ev & ~full;
    assign pop_acc  = pop_ev & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + ONE;
            out_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
        // A new error event overrides a same-cycle clear.
        if (push_ev && full) begin
            overflow_d = 1'b1;
        end
        if (pop_ev && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= inp_data;
        end
    end

    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // u_e: DEPTH 32 edge mode
    logic       e_push, e_pop, e_clr;
    logic [9:0] e_data, e_out;
    logic       e_empty, e_full, e_ae, e_af, e_ovf, e_unf;
    logic [5:0] e_size;

    // u_l: DEPTH 32 level mode
    logic       l_push, l_pop, l_clr;
    logic [9:0] l_data, l_out;
    logic       l_empty, l_full, l_ae, l_af, l_ovf, l_unf;
    logic [5:0] l_size;

    // u_w: DEPTH 4 edge mode
    logic       w_push, w_pop, w_clr;
    logic [9:0] w_data, w_out;
    logic       w_empty, w_full, w_ae, w_af, w_ovf, w_unf;
    logic [2:0] w_size;

    fifo_param #(.WIDTH(10), .DEPTH(32), .EDGE_MODE(1)) u_e (
        .clk(clk), .reset(reset), .push(e_push), .pop(e_pop), .inp_data(e_data),
        .clear_err(e_clr), .out_data(e_out), .empty(e_empty), .full(e_full),
        .almost_empty(e_ae), .almost_full(e_af), .cur_size(e_size),
        .overflow(e_ovf), .underflow(e_unf)
    );

    fifo_param #(.WIDTH(10), .DEPTH(32), .EDGE_MODE(0)) u_l (
        .clk(clk), .reset(reset), .push(l_push), .pop(l_pop), .inp_data(l_data),
        .clear_err(l_clr), .out_data(l_out), .empty(l_empty), .full(l_full),
        .almost_empty(l_ae), .almost_full(l_af), .cur_size(l_size),
        .overflow(l_ovf), .underflow(l_unf)
    );

    fifo_param #(.WIDTH(10), .DEPTH(4), .EDGE_MODE(1)) u_w (
        .clk(clk), .reset(reset), .push(w_push), .pop(w_pop), .inp_data(w_data),
        .clear_err(w_clr), .out_data(w_out), .empty(w_empty), .full(w_full),
        .almost_empty(w_ae), .almost_full(w_af), .cur_size(w_size),
        .overflow(w_ovf), .underflow(w_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_push_pulse(input logic [9:0] d);
        e_data = d;
        e_push = 1'b1;
        tick();
        e_push = 1'b0;
        tick();
    endtask

    task automatic e_pop_pulse();
        e_pop = 1'b1;
        tick();
        e_pop = 1'b0;
        tick();
    endtask

    task automatic e_both_pulse(input logic [9:0] d);
        e_data = d;
        e_push = 1'b1;
        e_pop  = 1'b1;
        tick();
        e_push = 1'b0;
        e_pop  = 1'b0;
        tick();
    endtask

    task automatic w_push_pulse(input logic [9:0] d);
        w_data = d;
        w_push = 1'b1;
        tick();
        w_push = 1'b0;
        tick();
    endtask

    task automatic w_pop_pulse();
        w_pop = 1'b1;
        tick();
        w_pop = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        e_push = 0; e_pop = 0; e_clr = 0; e_data = '0;
        l_push = 0; l_pop = 0; l_clr = 0; l_data = '0;
        w_push = 0; w_pop = 0; w_clr = 0; w_data = '0;
        tick();
        tick();

        chk("rst_empty", e_empty, 1);
        chk("rst_full", e_full, 0);
        chk("rst_size", e_size, 0);
        chk("rst_ae", e_ae, 1);
        chk("rst_af", e_af, 0);
        chk("rst_out", e_out, 0);
        chk("rst_ovf", e_ovf, 0);
        chk("rst_unf", e_unf, 0);
        reset = 1'b0;
        tick();

        // fill 1..32
        for (int k = 1; k <= 32; k++) begin
            e_push_pulse(10'(k));
            chk("fill_size", e_size, k);
            chk("fill_full", e_full, (k == 32));
            chk("fill_af", e_af, (k >= 30));
            chk("fill_ae", e_ae, (k <= 2));
        end
        e_push_pulse(10'd99);
        chk("ovf_set", e_ovf, 1);
        chk("ovf_size", e_size, 32);
        chk("ovf_full", e_full, 1);

        // drain in order
        for (int k = 1; k <= 32; k++) begin
            e_pop_pulse();
            chk("drain_out", e_out, k);
            chk("drain_size", e_size, 32 - k);
            chk("drain_empty", e_empty, (k == 32));
        end
        e_pop_pulse();
        chk("unf_set", e_unf, 1);
        chk("unf_out", e_out, 32);
        chk("unf_empty", e_empty, 1);

        // held push: one entry in edge mode, ten in level mode
        e_data = 10'd5;
        l_data = 10'd5;
        e_push = 1'b1;
        l_push = 1'b1;
        repeat (10) tick();
        e_push = 1'b0;
        l_push = 1'b0;
        tick();
        chk("held_edge_size", e_size, 1);
        chk("held_level_size", l_size, 10);

        // simultaneous push+pop at count 5
        e_push_pulse(10'h011);
        e_push_pulse(10'h022);
        e_push_pulse(10'h033);
        e_push_pulse(10'h044);
        chk("pre_sim_size", e_size, 5);
        e_both_pulse(10'h3AA);
        chk("sim5_size", e_size, 5);
        chk("sim5_out", e_out, 5);

        e_clr = 1'b1;
        tick();
        e_clr = 1'b0;
        chk("clr_ovf", e_ovf, 0);
        chk("clr_unf", e_unf, 0);

        e_pop_pulse(); chk("d5_out1", e_out, 10'h011);
        e_pop_pulse(); chk("d5_out2", e_out, 10'h022);
        e_pop_pulse(); chk("d5_out3", e_out, 10'h033);
        e_pop_pulse(); chk("d5_out4", e_out, 10'h044);
        e_pop_pulse(); chk("d5_out5", e_out, 10'h3AA);
        chk("d5_empty", e_empty, 1);

        // simultaneous on empty: push wins, no bypass, underflow flagged
        e_both_pulse(10'h155);
        chk("sim0_size", e_size, 1);
        chk("sim0_unf", e_unf, 1);
        chk("sim0_out", e_out, 10'h3AA);

        // simultaneous on full: pop wins, overflow flagged
        for (int i = 0; i < 31; i++) begin
            e_push_pulse(10'(10'h200 + i));
        end
        chk("pre_sim32_full", e_full, 1);
        e_both_pulse(10'h0AA);
        chk("sim32_size", e_size, 31);
        chk("sim32_ovf", e_ovf, 1);
        chk("sim32_out", e_out, 10'h155);
        chk("sim32_full", e_full, 0);

        for (int i = 0; i < 24; i++) begin
            e_pop_pulse();
        end
        chk("pre_rst_size", e_size, 7);
        chk("pre_rst_out", e_out, 10'h217);

        // wrap-around on DEPTH 4
        for (int i = 0; i < 10; i++) begin
            w_push_pulse(10'(i));
            chk("wrap_size", w_size, 1);
            w_pop_pulse();
            chk("wrap_out", w_out, i);
            chk("wrap_empty", w_empty, 1);
        end
        for (int i = 10; i < 14; i++) begin
            w_push_pulse(10'(i));
        end
        chk("wrap_full", w_full, 1);
        chk("wrap_full_size", w_size, 4);
        w_push_pulse(10'd14);
        chk("wrap_ovf", w_ovf, 1);
        chk("wrap_ovf_size", w_size, 4);
        w_pop_pulse();
        chk("wrap_pop_out", w_out, 10);
        chk("wrap_pop_full", w_full, 0);

        // asynchronous reset between edges
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_size", e_size, 0);
        chk("async_empty", e_empty, 1);
        chk("async_out", e_out, 0);
        chk("async_ovf", e_ovf, 0);
        #1 reset = 1'b0;
        tick();

        e_pop_pulse();
        chk("post_unf", e_unf, 1);
        e_pop = 1'b1;
        e_clr = 1'b1;
        tick();
        e_pop = 1'b0;
        e_clr = 1'b0;
        chk("set_beats_clr", e_unf, 1);
        tick();
        e_clr = 1'b1;
        tick();
        e_clr = 1'b0;
        chk("clr_unf_next", e_unf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
